cordic_rr_sched: RTL and testbench
==================================

Name: cordic_rr_sched

Overview:
- Round-robin scheduler that shares one pipelined CORDIC (valid_in/valid_out, fixed latency, no stall) between N_REQ requesters, e.g. the x/y/z accelerometer angle paths of the complementary filter.
- Accepts one operand set per cycle, issues it to the CORDIC, and tracks the requester id of each in-flight operation in a tag FIFO.
- Returns each result tagged with the id of the requester that issued it.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- DW, 17, signed width of x/y/theta operands and results (XY_BITS+1)
- MAX_INFLIGHT, 16, tag FIFO depth and credit limit (power of 2, >=2)
- IDW, 2, requester id width (ceil log2 N_REQ, min 1)
- WDOG_LIMIT, 64, watchdog cycle limit (used only with CORDIC_SCHED_WDOG_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- req_valid  in  N_REQ  per-requester operand valid
- req_x  in  N_REQ*DW  packed x operands; slice i belongs to requester i
- req_y  in  N_REQ*DW  packed y operands
- req_theta  in  N_REQ*DW  packed theta operands
- req_ready  out  N_REQ  one-hot combinational accept; transfer happens when req_valid[i]&req_ready[i]
- cor_valid_in  out  1  registered issue strobe to CORDIC
- cor_x_i, cor_y_i, cor_theta_i  out  DW each  registered operands to CORDIC
- cor_valid_out  in  1  CORDIC result strobe
- cor_x_o, cor_y_o, cor_theta_o  in  DW each  CORDIC results
- rsp_valid  out  1  registered result strobe, no backpressure
- rsp_id  out  IDW  requester id of the result
- rsp_x, rsp_y, rsp_theta  out  DW each  registered results
- inflight  out  log2(MAX_INFLIGHT)+1  in-flight count
- err_unexp  out  1  sticky flag: CORDIC result arrived with tag FIFO empty
- err_timeout  out  1  sticky flag: watchdog fired (0 when macro absent)

Behaviour:
- Reset (rst=0 at posedge): all registered outputs 0, FIFO empty, inflight=0, rr_ptr=N_REQ-1 so requester 0 has first priority, both error flags cleared.
- Grant (combinational):
  - When inflight<MAX_INFLIGHT, the first i with req_valid[i]=1, searching from (rr_ptr+1) mod N_REQ upward with wrap, gets req_ready[i]=1.
  - No grant when inflight==MAX_INFLIGHT. req_ready is never asserted for an idle requester.
- Accept cycle t:
  - rr_ptr<=i.
  - Slice i is registered onto cor_* with cor_valid_in=1 at t+1.
  - Id i is pushed into the tag FIFO.
  - On non-accept cycles, cor_valid_in=0 and cor_* data holds its last value.
- Return:
  - On cor_valid_out=1 with FIFO non-empty: pop the head id; next cycle rsp_valid=1, rsp_id=head, rsp_* = cor_* results.
  - Otherwise rsp_valid=0 and rsp data holds.
- End-to-end latency: accept at t -> rsp_valid at t+2+CORDIC latency. Results return in issue order.
- inflight: +1 on accept, -1 on pop; simultaneous accept and pop leaves it unchanged.
- Full: when inflight==MAX_INFLIGHT, a pop in the same cycle does not enable a grant that cycle; the grant resumes the next cycle.
- Underflow: cor_valid_out=1 with FIFO empty -> err_unexp<=1, no pop, rsp_valid=0.
- Mid-operation reset: flushes the FIFO and zeroes the counter. CORDIC results arriving after reset are treated as underflow and set err_unexp.
- Widths: data passes through unmodified; no arithmetic on operands.

Optional Feature:
- Macro: CORDIC_SCHED_WDOG_EN.
- Defined:
  - Watchdog counter resets on every pop and whenever inflight==0.
  - It increments on every other cycle while inflight!=0.
  - Reaching WDOG_LIMIT sets err_timeout (sticky), flushes the FIFO, sets inflight=0, and resets the counter.
- Not defined: no counter is built; err_timeout is tied 0.

Test Plan:
- Reset then idle -> all outputs 0, req_ready=0, rr_ptr selects requester 0 first.
- Single request: req_valid=3'b010, x=16384, y=0, theta=0, CORDIC model latency 16, accept at t -> cor_valid_in at t+1, rsp_valid at t+18 with rsp_id=1 and model result; inflight returns to 0.
- All three requesters held valid for 9 cycles -> grant order 0,1,2,0,1,2,0,1,2; nine responses with ids in the same order.
- Stalled CORDIC model (never returns) with continuous requests -> exactly 16 accepts, then req_ready=0 and inflight=16; one model return -> next grant occurs the cycle after the pop.
- Spurious cor_valid_out with an empty FIFO -> err_unexp=1, rsp_valid stays 0; err_unexp clears only on rst=0.
- With CORDIC_SCHED_WDOG_EN, WDOG_LIMIT=64, one request and no return -> err_timeout=1 exactly 64 cycles after cor_valid_in, inflight=0, a new request is accepted afterwards.

Source files
------------

// File: rtl/cordic_rr_sched.sv
// cordic_rr_sched: round-robin scheduler sharing one pipelined CORDIC between
// N_REQ requesters. A tag FIFO records the requester id of each in-flight
// operation so that results can be returned tagged with their owner.
// Optional watchdog: define CORDIC_SCHED_WDOG_EN.
module cordic_rr_sched #(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned DW           = 17,
  parameter int unsigned MAX_INFLIGHT = 16,
  parameter int unsigned IDW          = 2,
  parameter int unsigned WDOG_LIMIT   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DW-1:0]           req_x,
  input  logic [N_REQ*DW-1:0]           req_y,
  input  logic [N_REQ*DW-1:0]           req_theta,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          cor_valid_in,
  output logic [DW-1:0]                 cor_x_i,
  output logic [DW-1:0]                 cor_y_i,
  output logic [DW-1:0]                 cor_theta_i,
  input  logic                          cor_valid_out,
  input  logic [DW-1:0]                 cor_x_o,
  input  logic [DW-1:0]                 cor_y_o,
  input  logic [DW-1:0]                 cor_theta_o,
  output logic                          rsp_valid,
  output logic [IDW-1:0]                rsp_id,
  output logic [DW-1:0]                 rsp_x,
  output logic [DW-1:0]                 rsp_y,
  output logic [DW-1:0]                 rsp_theta,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err_unexp,
  output logic                          err_timeout
);

  localparam int unsigned AW = $clog2(MAX_INFLIGHT);
  localparam logic [AW:0] FULL = (AW+1)'(MAX_INFLIGHT);

  if (N_REQ < 2 || N_REQ > 8 || MAX_INFLIGHT < 2 ||
      (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0 ||
      WDOG_LIMIT < 1 || (1 << IDW) < N_REQ) begin : g_bad_param
    $error("cordic_rr_sched: illegal parameter set");
  end

  logic [IDW-1:0] rr_ptr;
  logic           hit_hi, hit_lo, grant, pop, wdog_fire;
  logic [IDW-1:0] id_hi, id_lo, gnt_id;
  logic [DW-1:0]  sel_x, sel_y, sel_theta;
  logic [IDW-1:0] tag_mem [MAX_INFLIGHT];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  // Rotating priority: first valid requester above rr_ptr, else first at or below it.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    id_hi  = '0;
    id_lo  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !hit_hi && (IDW'(i) > rr_ptr)) begin
        hit_hi = 1'b1;
        id_hi  = IDW'(i);
      end
      if (req_valid[i] && !hit_lo && (IDW'(i) <= rr_ptr)) begin
        hit_lo = 1'b1;
        id_lo  = IDW'(i);
      end
    end
    grant  = (inflight != FULL) && (hit_hi || hit_lo);
    gnt_id = hit_hi ? id_hi : id_lo;
  end

  assign req_ready = grant ? (N_REQ'(1) << gnt_id) : '0;
  assign pop       = cor_valid_out && (inflight != '0);

  // Operand mux selecting the granted requester's slices.
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_theta = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == gnt_id) begin
        sel_x     = req_x[i*DW +: DW];
        sel_y     = req_y[i*DW +: DW];
        sel_theta = req_theta[i*DW +: DW];
      end
    end
  end

`ifdef CORDIC_SCHED_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_LIMIT + 1);
  logic [WW-1:0] wdog_cnt;

  assign wdog_fire = (inflight != '0) && !pop && (wdog_cnt == WW'(WDOG_LIMIT - 1));

  // Watchdog: counts cycles without a pop while work is outstanding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_cnt    <= '0;
      err_timeout <= 1'b0;
    end else if (pop || (inflight == '0) || wdog_fire) begin
      wdog_cnt <= '0;
      if (wdog_fire) err_timeout <= 1'b1;
    end else begin
      wdog_cnt <= wdog_cnt + WW'(1);
    end
  end
`else
  assign wdog_fire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Tag storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= gnt_id;
  end

  // Issue, return, credit tracking and error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr       <= IDW'(N_REQ - 1);
      cor_valid_in <= 1'b0;
      cor_x_i      <= '0;
      cor_y_i      <= '0;
      cor_theta_i  <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_x        <= '0;
      rsp_y        <= '0;
      rsp_theta    <= '0;
      inflight     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_unexp    <= 1'b0;
    end else begin
      cor_valid_in <= grant;
      if (grant) begin
        rr_ptr      <= gnt_id;
        cor_x_i     <= sel_x;
        cor_y_i     <= sel_y;
        cor_theta_i <= sel_theta;
      end
      rsp_valid <= pop;
      if (pop) begin
        rsp_id    <= tag_mem[rd_ptr];
        rsp_x     <= cor_x_o;
        rsp_y     <= cor_y_o;
        rsp_theta <= cor_theta_o;
      end
      if (cor_valid_out && (inflight == '0)) err_unexp <= 1'b1;
      // A watchdog flush discards everything, including an accept in the same cycle.
      if (wdog_fire) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        inflight <= '0;
      end else begin
        if (grant) wr_ptr <= wr_ptr + AW'(1);
        if (pop)   rd_ptr <= rd_ptr + AW'(1);
        case ({grant, pop})
          2'b10:   inflight <= inflight + (AW+1)'(1);
          2'b01:   inflight <= inflight - (AW+1)'(1);
          default: inflight <= inflight;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Bench for cordic_rr_sched: a queue-based CORDIC model with stall and
// spurious-result injection, plus a cycle-level reference model of the
// scheduler built from its rules (rotating distance priority, id queue).
module tb_cordic_rr_sched;
  localparam int N   = 3;
  localparam int DW  = 17;
  localparam int MI  = 16;
  localparam int IDW = 2;
  localparam int WL  = 64;
  localparam int LAT = 16;
  localparam int IW  = $clog2(MI) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [N*DW-1:0] req_x, req_y, req_theta;
  logic            cor_valid_in, cor_valid_out;
  logic [DW-1:0]   cor_x_i, cor_y_i, cor_theta_i, cor_x_o, cor_y_o, cor_theta_o;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [DW-1:0]   rsp_x, rsp_y, rsp_theta;
  logic [IW-1:0]   inflight;
  logic            err_unexp, err_timeout;

  cordic_rr_sched #(.N_REQ(N), .DW(DW), .MAX_INFLIGHT(MI), .IDW(IDW), .WDOG_LIMIT(WL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_theta(req_theta),
    .req_ready(req_ready),
    .cor_valid_in(cor_valid_in), .cor_x_i(cor_x_i), .cor_y_i(cor_y_i), .cor_theta_i(cor_theta_i),
    .cor_valid_out(cor_valid_out), .cor_x_o(cor_x_o), .cor_y_o(cor_y_o), .cor_theta_o(cor_theta_o),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_theta(rsp_theta),
    .inflight(inflight), .err_unexp(err_unexp), .err_timeout(err_timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester drive
  logic [N-1:0]  rv = '0;
  logic [DW-1:0] rx [N];
  logic [DW-1:0] ry [N];
  logic [DW-1:0] rt [N];
  always_comb begin
    req_valid = rv;
    for (int i = 0; i < N; i++) begin
      req_x[i*DW +: DW]     = rx[i];
      req_y[i*DW +: DW]     = ry[i];
      req_theta[i*DW +: DW] = rt[i];
    end
  end

  // CORDIC model: fixed latency LAT, holds results while stalled, ignores reset.
  typedef struct { int stamp; logic [DW-1:0] x, y, t; } op_t;
  op_t cq[$];
  int  cyc_n = 0;
  logic stall = 1'b0, inj = 1'b0, mv = 1'b0;
  logic [DW-1:0] mx = '0, my = '0, mt = '0, ix = '0, iy = '0, it = '0;

  always @(posedge clk) begin
    op_t op;
    cyc_n++;
    if (cor_valid_in === 1'b1) cq.push_back('{cyc_n, cor_x_i, cor_y_i, cor_theta_i});
    if (!stall && cq.size() > 0 && cq[0].stamp + LAT - 1 <= cyc_n) begin
      op = cq.pop_front();
      mv <= 1'b1;
      mx <= op.y;
      my <= op.x;
      mt <= ~op.t;
    end else begin
      mv <= 1'b0;
    end
  end
  assign cor_valid_out = mv | inj;
  assign cor_x_o       = inj ? ix : mx;
  assign cor_y_o       = inj ? iy : my;
  assign cor_theta_o   = inj ? it : mt;

  // Reference model of the scheduler, checked every cycle at negedge.
  int   q_id[$];
  int   m_ptr = N - 1, m_wd = 0;
  bit   m_unexp = 0, m_to = 0, ok = 0;
  bit   e_cv = 0, e_rv = 0;
  int   e_rid = 0;
  logic [DW-1:0] e_cx = '0, e_cy = '0, e_ct = '0, e_rx = '0, e_ry = '0, e_rt = '0;
  int   acc_log[$];
  int   rsp_log[$];

  always @(negedge clk) begin
    int g, best, d;
    bit pop, fire;
    logic [N-1:0] e_ready;
    g = -1;
    best = N;
    for (int i = 0; i < N; i++) begin
      d = (i - m_ptr - 1 + 2 * N) % N;
      if (rv[i] && d < best) begin best = d; g = i; end
    end
    if (q_id.size() == MI) g = -1;
    e_ready = (g >= 0) ? (N'(1) << g) : '0;
    if (ok) begin
      check_eq("req_ready", req_ready, e_ready);
      check_eq("cor_valid_in", cor_valid_in, e_cv);
      check_eq("cor_x_i", cor_x_i, e_cx);
      check_eq("cor_y_i", cor_y_i, e_cy);
      check_eq("cor_theta_i", cor_theta_i, e_ct);
      check_eq("rsp_valid", rsp_valid, e_rv);
      check_eq("rsp_id", rsp_id, e_rid);
      check_eq("rsp_x", rsp_x, e_rx);
      check_eq("rsp_y", rsp_y, e_ry);
      check_eq("rsp_theta", rsp_theta, e_rt);
      check_eq("inflight", inflight, q_id.size());
      check_eq("err_unexp", err_unexp, m_unexp);
      check_eq("err_timeout", err_timeout, m_to);
      if (rsp_valid === 1'b1) rsp_log.push_back(int'(rsp_id));
      if (rst) for (int i = 0; i < N; i++) if (req_ready[i] && rv[i]) acc_log.push_back(i);
    end
    if (!rst) begin
      q_id.delete();
      m_ptr = N - 1; m_wd = 0; m_unexp = 0; m_to = 0;
      e_cv = 0; e_rv = 0; e_rid = 0;
      e_cx = '0; e_cy = '0; e_ct = '0; e_rx = '0; e_ry = '0; e_rt = '0;
      ok = 1;
    end else if (ok) begin
      pop = cor_valid_out && q_id.size() > 0;
      if (cor_valid_out && q_id.size() == 0) m_unexp = 1;
      fire = 0;
`ifdef CORDIC_SCHED_WDOG_EN
      if (pop || q_id.size() == 0) m_wd = 0;
      else if (m_wd == WL - 1) begin fire = 1; m_wd = 0; end
      else m_wd++;
`endif
      e_rv = pop;
      if (pop) begin
        e_rid = q_id.pop_front();
        e_rx = cor_x_o; e_ry = cor_y_o; e_rt = cor_theta_o;
      end
      e_cv = (g >= 0);
      if (g >= 0) begin
        e_cx = rx[g]; e_cy = ry[g]; e_ct = rt[g];
        q_id.push_back(g);
        m_ptr = g;
      end
      if (fire) begin m_to = 1; q_id.delete(); end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((inflight != '0 || cq.size() != 0 || mv) && n < 300) begin step(); n++; end
    check_eq("drain_bound", n < 300, 1'b1);
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin rx[i] = '0; ry[i] = '0; rt[i] = '0; end
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    check_eq("idle_ready", req_ready, '0);
    check_eq("idle_inflight", inflight, '0);

    // Single request from requester 1
    rv = 3'b010; rx[1] = 17'd16384; ry[1] = '0; rt[1] = '0;
    step();
    rv = '0;
    check_eq("single_cv", cor_valid_in, 1'b1);
    n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    check_eq("single_latency", n, 17);
    check_eq("single_id", rsp_id, 1);
    check_eq("single_ry", rsp_y, 17'd16384);
    check_eq("single_rx", rsp_x, '0);
    check_eq("single_rt", rsp_theta, 17'h1ffff);
    check_eq("single_inflight", inflight, '0);

    // Three requesters held valid for nine cycles from reset
    drain();
    reset_pulse();
    acc_log.delete(); rsp_log.delete();
    rv = '1;
    repeat (9) step();
    rv = '0;
    n = 0;
    while (rsp_log.size() < 9 && n < 60) begin step(); n++; end
    check_eq("rr_acc_count", acc_log.size(), 9);
    check_eq("rr_rsp_count", rsp_log.size(), 9);
    for (int i = 0; i < 9 && i < acc_log.size() && i < rsp_log.size(); i++) begin
      check_eq("rr_grant_order", acc_log[i], i % 3);
      check_eq("rr_rsp_order", rsp_log[i], i % 3);
    end

    // Stalled CORDIC: credit limit, then pop re-opens grant one cycle later
    drain();
    stall = 1'b1;
    acc_log.delete();
    rv = '1;
    repeat (24) step();
    check_eq("stall_accepts", acc_log.size(), 16);
    check_eq("stall_inflight", inflight, 5'd16);
    check_eq("stall_ready", req_ready, '0);
    stall = 1'b0;
    step();
    stall = 1'b1;
    check_eq("full_pop_strobe", cor_valid_out, 1'b1);
    check_eq("full_pop_ready", req_ready, '0);
    step();
    check_eq("resume_inflight", inflight, 5'd15);
    check_eq("resume_ready_any", req_ready != '0, 1'b1);
    step();
    rv = '0;
    check_eq("refill_inflight", inflight, 5'd16);
    stall = 1'b0;
    drain();

    // Spurious CORDIC result with empty FIFO
    inj = 1'b1; ix = 17'h1234; iy = 17'h0abc; it = 17'h1f00;
    step();
    inj = 1'b0;
    check_eq("unexp_set", err_unexp, 1'b1);
    check_eq("unexp_no_rsp", rsp_valid, 1'b0);
    repeat (5) step();
    check_eq("unexp_sticky", err_unexp, 1'b1);
    reset_pulse();
    step();
    check_eq("unexp_cleared", err_unexp, 1'b0);

    // Randomized traffic with a mid-operation reset
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        rx[i] = DW'($urandom); ry[i] = DW'($urandom); rt[i] = DW'($urandom);
      end
      rv = (c >= 147 && c < 150) ? '1 : N'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      if (c == 150) rst = 1'b0;
      step();
      rst = 1'b1;
    end
    rv = '0;
    stall = 1'b0;
    drain();
    check_eq("reset_flush_unexp", err_unexp, 1'b1);

`ifdef CORDIC_SCHED_WDOG_EN
    reset_pulse();
    stall = 1'b1;
    rv = 3'b001;
    step();
    rv = '0;
    n = 0;
    while (!err_timeout && n < 100) begin step(); n++; end
    check_eq("wdog_cycles", n, 64);
    check_eq("wdog_inflight", inflight, '0);
    rv = 3'b100;
    step();
    rv = '0;
    check_eq("wdog_new_accept", inflight, 5'd1);
    stall = 1'b0;
    drain();
`else
    check_eq("wdog_absent", err_timeout, 1'b0);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
